// File: rtl/carry_sel_adder_pkg.sv
// Shared constants and helpers for the carry-select adder.
// Default geometry is a 4-bit adder split into two 2-bit blocks.
package carry_sel_adder_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_BLK   = 2;

    // Number of carry-select blocks for a given geometry.
    function automatic int num_blocks(input int width, input int blk);
        return width / blk;
    endfunction

endpackage

// File: rtl/carry_sel_adder_rca_block.sv
// Combinational BLK-bit ripple-carry adder.
// This is the building block for every carry-select stage.
module rca_block
    import carry_sel_adder_pkg::*;
#(
    parameter int BLK = DEFAULT_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout
);

    logic [BLK:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar gi = 0; gi < BLK; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_carry[BLK];

endmodule

// File: rtl/carry_sel_adder.sv
// Registered carry-select adder: {cout, sum} = a + b + cin, one cycle latency.
// Block 0 ripples from cin; higher blocks precompute both carry cases and select.
module carry_sel_adder
    import carry_sel_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int BLK   = DEFAULT_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = num_blocks(WIDTH, BLK);

    generate
        if ((BLK < 1) || (WIDTH % BLK != 0)) begin : g_bad_geometry
            $error("carry_sel_adder: WIDTH must be a positive multiple of BLK");
        end
    endgenerate

    logic [NBLK:0]    w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    assign w_carry[0] = cin;

    rca_block #(.BLK(BLK)) u_blk0 (
        .a    (a[BLK-1:0]),
        .b    (b[BLK-1:0]),
        .cin  (w_carry[0]),
        .sum  (w_sum[BLK-1:0]),
        .cout (w_carry[1])
    );

    generate
        for (genvar gi = 1; gi < NBLK; gi++) begin : g_sel
            logic [BLK-1:0] w_sum0;
            logic [BLK-1:0] w_sum1;
            logic           w_cout0;
            logic           w_cout1;

            rca_block #(.BLK(BLK)) u_c0 (
                .a    (a[gi*BLK +: BLK]),
                .b    (b[gi*BLK +: BLK]),
                .cin  (1'b0),
                .sum  (w_sum0),
                .cout (w_cout0)
            );

            rca_block #(.BLK(BLK)) u_c1 (
                .a    (a[gi*BLK +: BLK]),
                .b    (b[gi*BLK +: BLK]),
                .cin  (1'b1),
                .sum  (w_sum1),
                .cout (w_cout1)
            );

            // Previous block's selected carry picks the precomputed result.
            assign w_sum[gi*BLK +: BLK] = w_carry[gi] ? w_sum1  : w_sum0;
            assign w_carry[gi+1]        = w_carry[gi] ? w_cout1 : w_cout0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_carry[NBLK];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_carry_sel_adder.sv
// Self-checking bench for carry_sel_adder: a 4/2 instance and an 8/4 instance
// driven in lockstep and compared against plain integer addition.
module tb_carry_sel_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a4, b4, sum4;
    logic       cin4, cout4;
    logic [7:0] a8, b8, sum8;
    logic       cin8, cout8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    carry_sel_adder #(.WIDTH(4), .BLK(2)) dut4 (
        .clk  (clk),
        .rst  (rst),
        .a    (a4),
        .b    (b4),
        .cin  (cin4),
        .sum  (sum4),
        .cout (cout4)
    );

    carry_sel_adder #(.WIDTH(8), .BLK(4)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .a    (a8),
        .b    (b8),
        .cin  (cin8),
        .sum  (sum8),
        .cout (cout8)
    );

    // Wait for the next rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
        #2;
        total++;
        if ({cout4, sum4} !== 5'd0) begin
            bad++;
            $display("FAIL reset_initial4: got %0d want 0", {cout4, sum4});
        end
        total++;
        if ({cout8, sum8} !== 9'd0) begin
            bad++;
            $display("FAIL reset_initial8: got %0d want 0", {cout8, sum8});
        end
        step();
        rst = 1'b0;
        a4 = 4'd9; b4 = 4'd3; cin4 = 1'b0;
        a8 = 8'd200; b8 = 8'd100; cin8 = 1'b0;
        step();
        total++;
        if ({cout4, sum4} !== 5'd12) begin
            bad++;
            $display("FAIL preload4: got %0d want 12", {cout4, sum4});
        end
        $display("preload 9+3+0 -> %0d", {cout4, sum4});
        // Asynchronous assert away from any clock edge.
        a4 = 4'd5; b4 = 4'd6; cin4 = 1'b1;
        a8 = 8'd5; b8 = 8'd6; cin8 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (sum4 !== 4'd0 || cout4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_async4: got sum=%0d cout=%0d want 0/0", sum4, cout4);
        end
        total++;
        if (sum8 !== 8'd0 || cout8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_async8: got sum=%0d cout=%0d want 0/0", sum8, cout8);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({cout4, sum4} !== 5'd0 || {cout8, sum8} !== 9'd0) begin
                bad++;
                $display("FAIL reset_hold: got %0d/%0d want 0/0", {cout4, sum4}, {cout8, sum8});
            end
        end
        rst = 1'b0;
        step();
        total++;
        if (sum4 !== 4'd12 || cout4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_release4: got sum=%0d cout=%0d want 12/0", sum4, cout4);
        end
        total++;
        if ({cout8, sum8} !== 9'd12) begin
            bad++;
            $display("FAIL reset_release8: got %0d want 12", {cout8, sum8});
        end
        $display("reset release 5+6+1 -> sum=%0d cout=%0d", sum4, cout4);
    endtask

    task automatic test_boundaries();
        int av[6] = '{7, 15, 0, 15, 10, 5};
        int bv[6] = '{8, 15, 0, 0, 5, 10};
        int cv[6] = '{1, 1, 0, 1, 0, 1};
        int a8v[6] = '{127, 255, 0, 255, 15, 240};
        int b8v[6] = '{128, 255, 0, 0, 0, 15};
        for (int i = 0; i < 6; i++) begin
            int e4, e8;
            a4 = 4'(av[i]); b4 = 4'(bv[i]); cin4 = cv[i][0];
            a8 = 8'(a8v[i]); b8 = 8'(b8v[i]); cin8 = cv[i][0];
            e4 = av[i] + bv[i] + cv[i];
            e8 = a8v[i] + b8v[i] + cv[i];
            step();
            total++;
            if ({cout4, sum4} !== 5'(e4)) begin
                bad++;
                $display("FAIL boundary4[%0d]: got %0d want %0d", i, {cout4, sum4}, e4);
            end
            total++;
            if ({cout8, sum8} !== 9'(e8)) begin
                bad++;
                $display("FAIL boundary8[%0d]: got %0d want %0d", i, {cout8, sum8}, e8);
            end
            $display("boundary %0d+%0d+%0d -> sum=%0d cout=%0d", av[i], bv[i], cv[i], sum4, cout4);
        end
    endtask

    task automatic test_back_to_back();
        a4 = 4'd3; b4 = 4'd4; cin4 = 1'b0;
        step();
        a4 = 4'd9; b4 = 4'd9; cin4 = 1'b0;
        total++;
        if (sum4 !== 4'd7 || cout4 !== 1'b0) begin
            bad++;
            $display("FAIL stream_first: got %0d/%0d want 7/0", sum4, cout4);
        end
        $display("stream 3+4 -> %0d/%0d", sum4, cout4);
        step();
        total++;
        if (sum4 !== 4'd2 || cout4 !== 1'b1) begin
            bad++;
            $display("FAIL stream_second: got %0d/%0d want 2/1", sum4, cout4);
        end
        $display("stream 9+9 -> %0d/%0d", sum4, cout4);
    endtask

    task automatic test_exhaustive();
        int errs4 = 0;
        int errs8 = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    int e4, e8, ra, rb, rc;
                    ra = int'($urandom_range(255));
                    rb = int'($urandom_range(255));
                    rc = int'($urandom_range(1));
                    a4 = 4'(x); b4 = 4'(y); cin4 = c[0];
                    a8 = 8'(ra); b8 = 8'(rb); cin8 = rc[0];
                    e4 = x + y + c;
                    e8 = ra + rb + rc;
                    step();
                    total++;
                    if ({cout4, sum4} !== 5'(e4)) begin
                        bad++; errs4++;
                        $display("FAIL exh4 %0d+%0d+%0d: got %0d want %0d", x, y, c, {cout4, sum4}, e4);
                    end
                    total++;
                    if ({cout8, sum8} !== 9'(e8)) begin
                        bad++; errs8++;
                        $display("FAIL rnd8 %0d+%0d+%0d: got %0d want %0d", ra, rb, rc, {cout8, sum8}, e8);
                    end
                end
            end
        end
        $display("exhaustive 4-bit: 512 vectors, %0d errors; random 8-bit: 512 vectors, %0d errors", errs4, errs8);
    endtask

    task automatic test_midstream_reset();
        a4 = 4'd1; b4 = 4'd2; cin4 = 1'b0;
        a8 = 8'd10; b8 = 8'd20; cin8 = 1'b0;
        step();
        total++;
        if ({cout4, sum4} !== 5'd3) begin
            bad++;
            $display("FAIL mid_first: got %0d want 3", {cout4, sum4});
        end
        // This operand is in flight when reset hits and must never appear.
        a4 = 4'd14; b4 = 4'd13; cin4 = 1'b1;
        a8 = 8'd250; b8 = 8'd9; cin8 = 1'b1;
        #1;
        rst = 1'b1;
        step();
        total++;
        if ({cout4, sum4} !== 5'd0 || {cout8, sum8} !== 9'd0) begin
            bad++;
            $display("FAIL mid_inflight: got %0d/%0d want 0/0", {cout4, sum4}, {cout8, sum8});
        end
        a4 = 4'd6; b4 = 4'd5; cin4 = 1'b0;
        a8 = 8'd100; b8 = 8'd155; cin8 = 1'b1;
        rst = 1'b0;
        #2;
        total++;
        if ({cout4, sum4} !== 5'd0 || {cout8, sum8} !== 9'd0) begin
            bad++;
            $display("FAIL mid_released_pre_edge: got %0d/%0d want 0/0", {cout4, sum4}, {cout8, sum8});
        end
        step();
        total++;
        if ({cout4, sum4} !== 5'd11) begin
            bad++;
            $display("FAIL mid_post4: got %0d want 11", {cout4, sum4});
        end
        total++;
        if ({cout8, sum8} !== 9'd256) begin
            bad++;
            $display("FAIL mid_post8: got %0d want 256", {cout8, sum8});
        end
        $display("mid-stream reset: post-release 6+5 -> %0d, 100+155+1 -> %0d", {cout4, sum4}, {cout8, sum8});
    endtask

    initial begin
        test_reset();
        test_boundaries();
        test_back_to_back();
        test_exhaustive();
        test_midstream_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
